// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Purpose  : Shared encodings for the MIPS control path: opcodes, ALUOp
//             codes, ALUSrcB / PCSource selects and the multi-cycle state set.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // ALU operation requests to the ALU control block
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Multi-cycle sequencer states
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_EXEC_I   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    // States that hold a memory request open and wait on mem_ready
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Purpose  : Counts memory wait cycles and flags a timeout once the count
//             reaches MEM_TIMEOUT-1 while the request is still not ready.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    input  logic restart,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count;

    // Wait counter: cleared on state entry, on ready and outside memory states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (restart || ready || !active) begin
            count <= 8'd0;
        end else if (count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // A ready in the final cycle wins over the timeout
    always_comb begin
        timeout = active && !ready && (count == LIMIT);
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Multi-cycle MIPS control FSM sequencing the shared datapath
//             through fetch/decode/execute/memory/writeback, with a memory
//             ready handshake, timeout abort and illegal opcode reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic       mem_err
);

    state_t     state;
    state_t     next_state;
    logic [5:0] op_q;
    logic       in_mem;
    logic       timeout;
    logic       restart;
    logic       unused_zero;

    // Zero is combined with PCWriteCond in the datapath, not here
    assign unused_zero = Zero;

    assign in_mem  = is_mem_state(state);
    assign restart = (next_state != state) || timeout;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (in_mem),
        .ready   (mem_ready),
        .restart (restart),
        .timeout (timeout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Opcode capture: only the value present in DECODE is used later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 6'd0;
        end else if (state == S_DECODE) begin
            op_q <= Op;
        end
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        case (state)
            S_RESET:    next_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    next_state = S_DECODE;
                else if (timeout) next_state = S_FETCH;
            end
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:              next_state = S_MEM_ADDR;
                    OP_RTYPE:                  next_state = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI:  next_state = S_EXEC_I;
                    OP_BEQ:                    next_state = S_BRANCH;
                    OP_J:                      next_state = S_JUMP;
                    default:                   next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: next_state = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)    next_state = S_MEM_WB;
                else if (timeout) next_state = S_FETCH;
            end
            S_MEM_WB:   next_state = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready || timeout) next_state = S_FETCH;
            end
            S_EXEC_R:   next_state = S_R_WB;
            S_R_WB:     next_state = S_FETCH;
            S_EXEC_I:   next_state = S_I_WB;
            S_I_WB:     next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
            default:    next_state = S_RESET;
        endcase
    end

    // Output decode from state, gated by mem_ready / timeout in memory states
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_ADD;
        PCSource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        mem_err     = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead  = !timeout;
                ALUSrcB  = SRCB_FOUR;
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
                mem_err  = timeout;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                case (Op)
                    OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_ANDI,
                    OP_ORI, OP_BEQ, OP_J:      illegal_op = 1'b0;
                    default:                   illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
                MemRead = !timeout;
                IorD    = 1'b1;
                mem_err = timeout;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = !timeout;
                IorD     = 1'b1;
                mem_err  = timeout;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                case (op_q)
                    OP_ANDI: ALUOp = ALU_AND;
                    OP_ORI:  ALUOp = ALU_OR;
                    default: ALUOp = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Directed self-checking bench for multicycle_control. Each cycle
//             pushes the expected control word to a scoreboard queue and pops
//             it against the sampled outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Op = 6'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal_op, mem_err;

    int tests = 0;
    int fails = 0;
    logic [18:0] sb_q[$];

    multicycle_control #(.MEM_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Op          (Op),
        .Zero        (Zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    logic [18:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                   PCSource, illegal_op, mem_err};

    function automatic logic [18:0] v(
        input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa,
        input logic [1:0] sb, input logic [2:0] aop, input logic [1:0] pcs,
        input logic ill, err);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, pcs, ill, err};
    endfunction

    //                                 pcw pcwc iord mr mw irw m2r rd rw sa  sb     aop     pcs  ill err
    localparam logic [18:0] E_IDLE     = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    localparam logic [18:0] E_F_WAIT   = v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0, 0);
    localparam logic [18:0] E_F_GO     = v(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0, 0);
    localparam logic [18:0] E_DEC      = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 0, 0);
    localparam logic [18:0] E_DEC_ILL  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 1, 0);
    localparam logic [18:0] E_MADDR    = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0, 0);
    localparam logic [18:0] E_MRD      = v(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    localparam logic [18:0] E_MWB      = v(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    localparam logic [18:0] E_MWR      = v(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    localparam logic [18:0] E_MWR_TO   = v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1);
    localparam logic [18:0] E_EXR      = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0, 0);
    localparam logic [18:0] E_RWB      = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    localparam logic [18:0] E_EXI_ADD  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0, 0);
    localparam logic [18:0] E_EXI_AND  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 2'b00, 0, 0);
    localparam logic [18:0] E_EXI_OR   = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b011, 2'b00, 0, 0);
    localparam logic [18:0] E_IWB      = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    localparam logic [18:0] E_BR       = v(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 0, 0);
    localparam logic [18:0] E_JMP      = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0, 0);

    // Pop one expectation and compare against the sampled control word
    task automatic check(input string tag);
        logic [18:0] e;
        e = sb_q.pop_front();
        tests++;
        assert (ctrl === e) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, ctrl, e);
        end
    endtask

    // One cycle: drive inputs at negedge, queue expectation, sample 1ns later
    task automatic step(input string tag, input logic [5:0] op_i,
                        input logic rdy, input logic z, input logic [18:0] exp);
        @(negedge clk);
        Op        = op_i;
        mem_ready = rdy;
        Zero      = z;
        sb_q.push_back(exp);
        #1;
        check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and release
        step("reset0", 6'd0, 1'b1, 1'b0, E_IDLE);
        step("reset1", 6'd0, 1'b1, 1'b0, E_IDLE);
        @(posedge clk); #1 rst_n = 1'b1;
        step("reset_state", 6'd0, 1'b1, 1'b0, E_IDLE);
        step("first_fetch_wait", 6'd0, 1'b0, 1'b0, E_F_WAIT);

        // R-type, zero wait: back in FETCH on cycle 5
        step("r_fetch",  6'd0, 1'b1, 1'b0, E_F_GO);
        step("r_decode", 6'd0, 1'b1, 1'b0, E_DEC);
        step("r_exec",   6'd35, 1'b1, 1'b0, E_EXR);
        step("r_wb",     6'd43, 1'b1, 1'b0, E_RWB);

        // LW with three wait cycles in MEM_RD; Op changes after DECODE
        step("lw_fetch", 6'd0, 1'b1, 1'b0, E_F_GO);
        step("lw_decode", 6'd35, 1'b1, 1'b0, E_DEC);
        step("lw_addr",  6'd43, 1'b1, 1'b0, E_MADDR);
        for (int i = 0; i < 3; i++) step("lw_rd_wait", 6'd43, 1'b0, 1'b0, E_MRD);
        step("lw_rd_go", 6'd43, 1'b1, 1'b0, E_MRD);
        step("lw_wb",    6'd43, 1'b0, 1'b0, E_MWB);
        step("lw_refetch", 6'd0, 1'b0, 1'b0, E_F_WAIT);

        // SW zero wait
        step("sw_fetch", 6'd0, 1'b1, 1'b0, E_F_GO);
        step("sw_decode", 6'd43, 1'b1, 1'b0, E_DEC);
        step("sw_addr",  6'd35, 1'b1, 1'b0, E_MADDR);
        step("sw_wr",    6'd35, 1'b1, 1'b0, E_MWR);

        // I-type ALU selection from the latched opcode
        step("addi_fetch", 6'd0, 1'b1, 1'b0, E_F_GO);
        step("addi_decode", 6'd8, 1'b1, 1'b0, E_DEC);
        step("addi_exec", 6'd12, 1'b1, 1'b0, E_EXI_ADD);
        step("addi_wb",  6'd12, 1'b1, 1'b0, E_IWB);
        step("andi_fetch", 6'd0, 1'b1, 1'b0, E_F_GO);
        step("andi_decode", 6'd12, 1'b1, 1'b0, E_DEC);
        step("andi_exec", 6'd13, 1'b1, 1'b0, E_EXI_AND);
        step("andi_wb",  6'd13, 1'b1, 1'b0, E_IWB);
        step("ori_fetch", 6'd0, 1'b1, 1'b0, E_F_GO);
        step("ori_decode", 6'd13, 1'b1, 1'b0, E_DEC);
        step("ori_exec", 6'd8, 1'b1, 1'b0, E_EXI_OR);
        step("ori_wb",   6'd8, 1'b1, 1'b0, E_IWB);

        // BEQ and J
        step("beq_fetch", 6'd0, 1'b1, 1'b0, E_F_GO);
        step("beq_decode", 6'd4, 1'b1, 1'b1, E_DEC);
        step("beq_branch", 6'd4, 1'b1, 1'b1, E_BR);
        step("j_fetch",  6'd0, 1'b1, 1'b0, E_F_GO);
        step("j_decode", 6'd2, 1'b1, 1'b0, E_DEC);
        step("j_jump",   6'd2, 1'b1, 1'b0, E_JMP);

        // Illegal opcode
        step("ill_fetch", 6'd0, 1'b1, 1'b0, E_F_GO);
        step("ill_decode", 6'd54, 1'b1, 1'b0, E_DEC_ILL);
        step("ill_refetch", 6'd54, 1'b0, 1'b0, E_F_WAIT);
        step("ill_fetch2", 6'd0, 1'b1, 1'b0, E_F_GO);

        // SW timeout: mem_err on the 16th MEM_WR cycle
        step("swto_decode", 6'd43, 1'b1, 1'b0, E_DEC);
        step("swto_addr", 6'd43, 1'b1, 1'b0, E_MADDR);
        for (int i = 0; i < 15; i++) step("swto_wait", 6'd43, 1'b0, 1'b0, E_MWR);
        step("swto_err", 6'd43, 1'b0, 1'b0, E_MWR_TO);
        step("swto_after", 6'd43, 1'b0, 1'b0, E_F_WAIT);

        // SW with ready on cycle 16: success, no mem_err
        step("swok_fetch", 6'd0, 1'b1, 1'b0, E_F_GO);
        step("swok_decode", 6'd43, 1'b1, 1'b0, E_DEC);
        step("swok_addr", 6'd43, 1'b1, 1'b0, E_MADDR);
        for (int i = 0; i < 15; i++) step("swok_wait", 6'd43, 1'b0, 1'b0, E_MWR);
        step("swok_ready16", 6'd43, 1'b1, 1'b0, E_MWR);
        step("swok_after", 6'd0, 1'b0, 1'b0, E_F_WAIT);

        // Asynchronous reset in the middle of an LW
        step("lwrst_fetch", 6'd0, 1'b1, 1'b0, E_F_GO);
        step("lwrst_decode", 6'd35, 1'b1, 1'b0, E_DEC);
        step("lwrst_addr", 6'd35, 1'b1, 1'b0, E_MADDR);
        step("lwrst_rd", 6'd35, 1'b0, 1'b0, E_MRD);
        #1 rst_n = 1'b0;
        sb_q.push_back(E_IDLE);
        #1 check("async_reset_drop");
        step("in_reset", 6'd35, 1'b1, 1'b0, E_IDLE);
        @(posedge clk); #1 rst_n = 1'b1;
        step("post_reset_state", 6'd35, 1'b0, 1'b0, E_IDLE);
        step("post_reset_fetch", 6'd35, 1'b0, 1'b0, E_F_WAIT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
